// File: rtl/dsp_pkg.sv
// Shared definitions for the dsp_mac_ctrl sequencer. Holds the slice OPMODE
// words, the FSM state encoding, the per-cycle tag carried alongside the slice
// pipeline, and helpers for latency and OPMODE selection.
package dsp_pkg;

    localparam int unsigned OPM_W = 8;

    // OPMODE words; the upper nibble is always zero
    localparam logic [OPM_W-1:0] OPM_FIRST = 8'h01;   // X=M, Z=0: start a new sum
    localparam logic [OPM_W-1:0] OPM_ACC   = 8'h09;   // X=M, Z=P: accumulate
    localparam logic [OPM_W-1:0] OPM_HOLD  = 8'h08;   // X=0, Z=P: hold P

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One tag per cycle. v marks an accepted sample and first marks the first
    // accepted sample of a job.
    typedef struct packed {
        logic v;
        logic first;
    } tag_t;

    // Cycles from the accept edge until the product is held in the M register
    function automatic int unsigned lat_m(input int unsigned a0reg,
                                          input int unsigned a1reg,
                                          input int unsigned mreg);
        return a0reg + a1reg + mreg;
    endfunction

    // OPMODE applied to the slice for a given tag
    function automatic logic [OPM_W-1:0] opmode_of(input tag_t t);
        logic [OPM_W-1:0] opm;
        opm = OPM_HOLD;
        if (t.first) begin
            opm = OPM_FIRST;
        end else if (t.v) begin
            opm = OPM_ACC;
        end
        return opm;
    endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// Shift register of per-cycle tags that runs alongside the slice pipeline.
// A tap at depth d presents the tag that was pushed d clock edges earlier;
// depth 0 presents the current push directly.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : tag entering the pipe this cycle
//   tap_op     : full tag at depth TAP_OP (drives OPMODE selection)
//   tap_p_v    : valid bit at depth TAP_P (aligned with the slice P output)
module dsp_tag_pipe
    import dsp_pkg::*;
#(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned TAP_OP = 1,
    parameter int unsigned TAP_P  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t push,
    output tag_t tap_op,
    output logic tap_p_v
);

    // stage_q[i] holds the tag pushed i+1 edges ago
    tag_t stage_q [DEPTH];

    // Shift stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // OPMODE tap
    if (TAP_OP == 0) begin : g_op_direct
        assign tap_op = push;
    end else begin : g_op_reg
        assign tap_op = stage_q[TAP_OP-1];
    end

    // P tap
    if (TAP_P == 0) begin : g_p_direct
        assign tap_p_v = push.v;
    end else begin : g_p_reg
        assign tap_p_v = stage_q[TAP_P-1].v;
    end

endmodule

// File: rtl/dsp_mac_ctrl.sv
// Sequencer that drives one DSP slice as an N-term unsigned multiply-
// accumulate engine. A job (START+LEN) streams LEN (a,b) pairs through the
// slice; after the slice pipeline drains, P is captured and returned as one
// result with valid/ready.
// Configuration macro: DSP_MAC_CTRL_SAT_EN -- when defined, a job that saw a
// carry-out returns all ones instead of the wrapped sum.
// Ports:
//   CLK, RSTN            : clock, asynchronous active-low reset
//   START, LEN, BUSY     : job request / term count / engine busy
//   S_VALID, S_READY     : sample handshake
//   S_A, S_B             : sample operands
//   DSP_A, DSP_B         : slice operands (pass-through of S_A/S_B)
//   DSP_OPMODE, DSP_CE   : slice OPMODE and clock enables
//   DSP_RSTP             : slice P/M synchronous reset
//   DSP_P, DSP_CARRYOUT  : slice result and carry-out
//   R_VALID, R_READY     : result handshake
//   R_DATA, R_OVF        : accumulated sum and sticky overflow
module dsp_mac_ctrl
    import dsp_pkg::*;
#(
    parameter int unsigned ABD_WIDTH = 18,
    parameter int unsigned CP_WIDTH  = 48,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned A0REG     = 0,
    parameter int unsigned A1REG     = 1,
    parameter int unsigned MREG      = 1,
    parameter int unsigned OPMODEREG = 1,
    parameter int unsigned PREG      = 1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 START,
    input  logic [CNT_W-1:0]     LEN,
    output logic                 BUSY,
    input  logic                 S_VALID,
    output logic                 S_READY,
    input  logic [ABD_WIDTH-1:0] S_A,
    input  logic [ABD_WIDTH-1:0] S_B,
    output logic [ABD_WIDTH-1:0] DSP_A,
    output logic [ABD_WIDTH-1:0] DSP_B,
    output logic [OPM_W-1:0]     DSP_OPMODE,
    output logic                 DSP_CE,
    output logic                 DSP_RSTP,
    input  logic [CP_WIDTH-1:0]  DSP_P,
    input  logic                 DSP_CARRYOUT,
    output logic                 R_VALID,
    input  logic                 R_READY,
    output logic [CP_WIDTH-1:0]  R_DATA,
    output logic                 R_OVF
);

    localparam int unsigned LAT_M   = lat_m(A0REG, A1REG, MREG);
    localparam int unsigned OPM_TAP = LAT_M - OPMODEREG;
    localparam int unsigned P_TAP   = LAT_M + PREG;
    localparam int unsigned DRAIN_W = (P_TAP > 1) ? $clog2(P_TAP) : 1;

    state_t               state;
    state_t               state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     len_q;
    logic [DRAIN_W-1:0]   dcnt;
    logic                 accept;
    logic                 last_accept;
    logic                 drain_done;
    logic                 job_start;
    logic                 ovf_nx;
    tag_t                 push;
    tag_t                 tap_op;
    logic                 tap_p_v;
    logic [CP_WIDTH-1:0]  r_data_q;
    logic                 r_ovf_q;
    logic                 rstp_q;
    logic                 ce_q;

    // Operands go straight to the slice; its A/B registers do the sampling
    assign DSP_A = S_A;
    assign DSP_B = S_B;

    assign accept      = S_VALID && S_READY;
    assign last_accept = accept && ((cnt + CNT_W'(1)) == len_q);
    assign drain_done  = (state == S_DRAIN) && (dcnt == DRAIN_W'(P_TAP - 1));
    assign job_start   = (state == S_IDLE) && START;

    // Carry-out only counts on cycles where P holds a sample's contribution
    assign ovf_nx = r_ovf_q | (tap_p_v & DSP_CARRYOUT);

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nx = (LEN == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (last_accept) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (R_READY) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        BUSY    = 1'b0;
        S_READY = 1'b0;
        R_VALID = 1'b0;
        case (state)
            S_IDLE: begin
            end
            S_ACCUM: begin
                BUSY    = 1'b1;
                S_READY = (cnt < len_q);
            end
            S_DRAIN: begin
                BUSY = 1'b1;
            end
            S_DONE: begin
                BUSY    = 1'b1;
                R_VALID = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Sample/drain counters and result capture
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt      <= '0;
            len_q    <= '0;
            dcnt     <= '0;
            r_data_q <= '0;
            r_ovf_q  <= 1'b0;
        end else if (job_start) begin
            cnt      <= '0;
            len_q    <= LEN;
            dcnt     <= '0;
            r_data_q <= '0;
            r_ovf_q  <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == S_DRAIN) begin
                dcnt <= dcnt + DRAIN_W'(1);
            end
            r_ovf_q <= ovf_nx;
            if (drain_done) begin
`ifdef DSP_MAC_CTRL_SAT_EN
                r_data_q <= ovf_nx ? {CP_WIDTH{1'b1}} : DSP_P;
`else
                r_data_q <= DSP_P;
`endif
            end
        end
    end

    assign R_DATA = r_data_q;
    assign R_OVF  = r_ovf_q;

    // Slice control: CE held high out of reset; RSTP tracks the IDLE state
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ce_q   <= 1'b0;
            rstp_q <= 1'b0;
        end else begin
            ce_q   <= 1'b1;
            rstp_q <= (state_nx == S_IDLE);
        end
    end

    assign DSP_CE   = ce_q;
    assign DSP_RSTP = rstp_q;

    // Tag pipe aligns OPMODE and carry-out sampling with the slice latency
    assign push.v     = accept;
    assign push.first = accept && (cnt == '0);

    dsp_tag_pipe #(
        .DEPTH  (P_TAP),
        .TAP_OP (OPM_TAP),
        .TAP_P  (P_TAP)
    ) u_tag_pipe (
        .clk     (CLK),
        .rst_n   (RSTN),
        .push    (push),
        .tap_op  (tap_op),
        .tap_p_v (tap_p_v)
    );

    // A bubble pushes v=0, which maps to HOLD so the sum is untouched
    assign DSP_OPMODE = opmode_of(tap_op);

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Bench for dsp_mac_ctrl with a behavioural slice model (A1REG=1, MREG=1,
// OPMODEREG=1, PREG=1, CARRYOUTREG=1). Expected results go into a queue when
// a job is issued; a monitor pops and compares on every result handshake.
module tb_dsp_mac_ctrl;

    logic        clk = 1'b0;
    logic        RSTN;
    logic        START;
    logic [15:0] LEN;
    logic        BUSY;
    logic        S_VALID;
    logic        S_READY;
    logic [17:0] S_A, S_B;
    logic [17:0] DSP_A, DSP_B;
    logic [7:0]  DSP_OPMODE;
    logic        DSP_CE;
    logic        DSP_RSTP;
    logic [47:0] DSP_P;
    logic        DSP_CARRYOUT;
    logic        R_VALID;
    logic        R_READY;
    logic [47:0] R_DATA;
    logic        R_OVF;

    dsp_mac_ctrl dut (
        .CLK          (clk),
        .RSTN         (RSTN),
        .START        (START),
        .LEN          (LEN),
        .BUSY         (BUSY),
        .S_VALID      (S_VALID),
        .S_READY      (S_READY),
        .S_A          (S_A),
        .S_B          (S_B),
        .DSP_A        (DSP_A),
        .DSP_B        (DSP_B),
        .DSP_OPMODE   (DSP_OPMODE),
        .DSP_CE       (DSP_CE),
        .DSP_RSTP     (DSP_RSTP),
        .DSP_P        (DSP_P),
        .DSP_CARRYOUT (DSP_CARRYOUT),
        .R_VALID      (R_VALID),
        .R_READY      (R_READY),
        .R_DATA       (R_DATA),
        .R_OVF        (R_OVF)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slice model
    logic [17:0] m_a1 = '0, m_b1 = '0;
    logic [47:0] m_m = '0, m_p = '0;
    logic [7:0]  m_opm = 8'h08;
    logic        m_cy = 1'b0;
    logic [47:0] m_x, m_z;

    assign m_x = (m_opm[1:0] == 2'b01) ? m_m : 48'd0;
    assign m_z = (m_opm[3:2] == 2'b10) ? m_p : 48'd0;

    always @(posedge clk) begin
        if (DSP_CE) begin
            m_a1  <= DSP_A;
            m_b1  <= DSP_B;
            m_opm <= DSP_OPMODE;
            if (DSP_RSTP) begin
                m_m  <= '0;
                m_p  <= '0;
                m_cy <= 1'b0;
            end else begin
                m_m          <= 48'(m_a1) * 48'(m_b1);
                {m_cy, m_p}  <= 49'(m_z) + 49'(m_x);
            end
        end
    end

    assign DSP_P        = m_p;
    assign DSP_CARRYOUT = m_cy;

    // Scoreboard
    typedef struct packed {
        logic [47:0] data;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   va[8];
    int   vb[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares on every result handshake
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (RSTN && R_VALID && R_READY) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got result 0x%0h, expected none", R_DATA);
            end else begin
                e = sb.pop_front();
                check("result_data", 64'(R_DATA), 64'(e.data));
                check("result_ovf", 64'(R_OVF), 64'(e.ovf));
            end
        end
    end

    // Drive one sample starting at a negedge; returns at the negedge after the accept
    task automatic push_sample(input logic [17:0] a, input logic [17:0] b, output int acc_cyc);
        bit done;
        done    = 1'b0;
        acc_cyc = cyc;
        S_VALID = 1'b1;
        S_A     = a;
        S_B     = b;
        for (int i = 0; i < 100 && !done; i++) begin
            if (S_READY) begin
                acc_cyc = cyc;
                done    = 1'b1;
            end
            @(negedge clk);
        end
        S_VALID = 1'b0;
        if (!done) check("s_ready_timeout", 64'(0), 64'(1));
    endtask

    // Issue a job and wait for R_VALID; exp_lat counts edges from the last
    // accept (or from START when len==0) to R_VALID visible
    task automatic run_job(input int len, input int gap, input logic ones,
                           input logic [47:0] exp_data, input logic exp_ovf,
                           input int exp_lat);
        int  start_c, acc, ref_c;
        bit  seen;
        sb.push_back(exp_t'{data: exp_data, ovf: exp_ovf});
        START   = 1'b1;
        LEN     = 16'(len);
        start_c = cyc;
        acc     = cyc;
        @(negedge clk);
        START = 1'b0;
        check("busy_after_start", 64'(BUSY), 64'(1));
        if (len == 0) check("s_ready_len0", 64'(S_READY), 64'(0));
        for (int i = 0; i < len; i++) begin
            if (ones) push_sample(18'h3FFFF, 18'h3FFFF, acc);
            else      push_sample(18'(va[i]), 18'(vb[i]), acc);
            if (i != len - 1) repeat (gap) @(negedge clk);
        end
        ref_c = (len == 0) ? start_c : acc;
        seen  = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (R_VALID) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check("r_valid_timeout", 64'(0), 64'(1));
        else if (exp_lat > 0) check("latency", 64'(cyc - ref_c), 64'(exp_lat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN    = 1'b0;
        START   = 1'b0;
        LEN     = '0;
        S_VALID = 1'b0;
        S_A     = '0;
        S_B     = '0;
        R_READY = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_s_ready", 64'(S_READY), 64'(0));
        check("rst_r_valid", 64'(R_VALID), 64'(0));
        check("rst_r_data", 64'(R_DATA), 64'(0));
        check("rst_opmode", 64'(DSP_OPMODE), 64'h08);
        check("rst_ce", 64'(DSP_CE), 64'(0));
        check("rst_rstp", 64'(DSP_RSTP), 64'(0));
        RSTN = 1'b1;
        @(negedge clk);
        check("idle_ce", 64'(DSP_CE), 64'(1));
        check("idle_rstp", 64'(DSP_RSTP), 64'(1));
        @(negedge clk);

        // 1: back-to-back, 1*5+2*6+3*7+4*8 = 70
        va = '{1, 2, 3, 4, 0, 0, 0, 0};
        vb = '{5, 6, 7, 8, 0, 0, 0, 0};
        run_job(4, 0, 1'b0, 48'd70, 1'b0, 4);
        repeat (2) @(negedge clk);

        // 2: same job with 3-cycle bubbles
        run_job(4, 3, 1'b0, 48'd70, 1'b0, 4);
        repeat (2) @(negedge clk);

        // 3: empty job
        run_job(0, 0, 1'b0, 48'd0, 1'b0, 1);
        repeat (2) @(negedge clk);

        // 4: 4097 * (2^18-1)^2 wraps once past 2^48
`ifdef DSP_MAC_CTRL_SAT_EN
        run_job(4097, 0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1, 4);
`else
        run_job(4097, 0, 1'b1, 48'h000F_7FF8_1001, 1'b1, 4);
`endif
        repeat (2) @(negedge clk);

        // 5: result held under backpressure, START ignored; 5*7+6*8 = 83
        va = '{5, 6, 0, 0, 0, 0, 0, 0};
        vb = '{7, 8, 0, 0, 0, 0, 0, 0};
        R_READY = 1'b0;
        run_job(2, 0, 1'b0, 48'd83, 1'b0, 4);
        for (int i = 0; i < 10; i++) begin
            START = i[0];
            LEN   = 16'd3;
            @(negedge clk);
            check("hold_r_data", 64'(R_DATA), 64'd83);
            check("hold_r_valid", 64'(R_VALID), 64'(1));
            check("hold_s_ready", 64'(S_READY), 64'(0));
        end
        START   = 1'b0;
        R_READY = 1'b1;
        repeat (2) @(negedge clk);
        va = '{2, 0, 0, 0, 0, 0, 0, 0};
        vb = '{3, 0, 0, 0, 0, 0, 0, 0};
        run_job(1, 0, 1'b0, 48'd6, 1'b0, 4);
        repeat (2) @(negedge clk);

        // 6: reset after 2 of 4 accepts, then 3*3+4*4 = 25
        va = '{1, 2, 3, 4, 0, 0, 0, 0};
        vb = '{5, 6, 7, 8, 0, 0, 0, 0};
        START = 1'b1;
        LEN   = 16'd4;
        @(negedge clk);
        START = 1'b0;
        begin
            int acc;
            push_sample(18'd1, 18'd5, acc);
            push_sample(18'd2, 18'd6, acc);
        end
        S_A  = '0;
        S_B  = '0;
        RSTN = 1'b0;
        #1;
        check("midrst_busy", 64'(BUSY), 64'(0));
        check("midrst_s_ready", 64'(S_READY), 64'(0));
        check("midrst_r_valid", 64'(R_VALID), 64'(0));
        check("midrst_opmode", 64'(DSP_OPMODE), 64'h08);
        check("midrst_ce_rstp", 64'({DSP_CE, DSP_RSTP}), 64'(0));
        repeat (2) @(negedge clk);
        RSTN = 1'b1;
        repeat (2) @(negedge clk);
        va = '{3, 4, 0, 0, 0, 0, 0, 0};
        vb = '{3, 4, 0, 0, 0, 0, 0, 0};
        run_job(2, 0, 1'b0, 48'd25, 1'b0, 4);
        repeat (4) @(negedge clk);

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
